nand_flash_target: RTL and testbench

Synthesizable NAND flash target model that responds to the flash controller's pin-level bus: CE_N, CLE, ALE, WE_N, RE_N, WP_N in; R/B_N and read data out. It decodes the command/address/data cycles the controller issues and holds a small page array behind a page register. It sits opposite the controller in simulation and FPGA loopback builds, so the controller's state machine can be exercised without a physical device. Everything is synchronous to the controller clock; pin strobes are edge-detected in that clock domain.

---
 rtl/nand_flash_target.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_nand_flash_target.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/nand_flash_target.sv
// -----------------------------------------------------------------------------
// nand_flash_target
//
// Behavioural-but-synthesizable NAND flash target for loopback against a
// flash controller. Decodes command / address / data cycles from the pin-level
// bus, holds a small page array behind a page register, and models ready/busy
// timing for read, program and reset.
//
// Ports:
//   clk         system clock (controller clock)
//   rst         synchronous active-low reset
//   iCE_N       chip enable, active low; high masks all strobes
//   iCLE        command latch enable
//   iALE        address latch enable
//   iWE_N       write enable; byte latched on rising edge
//   iRE_N       read enable; data driven after falling edge
//   iWP_N       write protect, active low
//   flash_data  byte bus from controller
//   oRB_N       ready/busy, low = busy
//   flash_q     read data to controller
//   q_oe        high while the target drives flash_q
// -----------------------------------------------------------------------------
module nand_flash_target #(
    parameter int unsigned PAGE_BYTES = 16,
    parameter int unsigned NUM_PAGES  = 4,
    parameter int unsigned READ_BUSY  = 8,
    parameter int unsigned PROG_BUSY  = 20,
    parameter int unsigned RST_BUSY   = 4,
    parameter logic [7:0]  ID_BYTE0   = 8'hEC,
    parameter logic [7:0]  ID_BYTE1   = 8'hD3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iCE_N,
    input  logic       iCLE,
    input  logic       iALE,
    input  logic       iWE_N,
    input  logic       iRE_N,
    input  logic       iWP_N,
    input  logic [7:0] flash_data,
    output logic       oRB_N,
    output logic [7:0] flash_q,
    output logic       q_oe
);

    localparam int unsigned ColW    = (PAGE_BYTES > 1) ? $clog2(PAGE_BYTES) : 1;
    localparam int unsigned RowW    = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
    localparam int unsigned BusyMax0 = (READ_BUSY > PROG_BUSY) ? READ_BUSY : PROG_BUSY;
    localparam int unsigned BusyMax = (BusyMax0 > RST_BUSY) ? BusyMax0 : RST_BUSY;
    localparam int unsigned BusyW   = $clog2(BusyMax + 2);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StRdConf,
        StProgData,
        StBusy,
        StOutPage,
        StOutStatus,
        StOutId
    } state_e;

    // Which command opened the current address phase.
    typedef enum logic [1:0] {
        OpRead,
        OpProg,
        OpId
    } op_e;

    typedef logic [PAGE_BYTES-1:0][7:0] page_t;

    // Input sampling stage
    logic       we_q, re_q, cle_q, ale_q;
    logic [7:0] data_q;

    // Control state
    state_e           state_q, state_d;
    state_e           busy_next_q, busy_next_d;
    op_e              op_q, op_d;
    logic             addr_cnt_q, addr_cnt_d;
    logic [ColW-1:0]  col_q, col_d;
    logic [RowW-1:0]  row_q, row_d;
    logic             fail_q, fail_d;
    logic [BusyW-1:0] busy_cnt_q, busy_cnt_d;
    logic             rb_n_q, rb_n_d;
    logic [1:0]       id_idx_q, id_idx_d;
    logic [7:0]       flash_q_q, flash_q_d;
    logic             q_oe_q, q_oe_d;

    // Storage
    page_t                         page_q, page_d;
    logic [NUM_PAGES-1:0][PAGE_BYTES*8-1:0] array_q, array_d;

    // Strobe detection
    logic wr_stb, cmd_stb, addr_stb, data_stb, rd_fall, rd_rise;

    assign wr_stb   = !we_q && iWE_N && !iCE_N;
    assign cmd_stb  = wr_stb && cle_q && !ale_q;
    assign addr_stb = wr_stb && ale_q && !cle_q;
    assign data_stb = wr_stb && !cle_q && !ale_q;
    assign rd_fall  = re_q && !iRE_N && !iCE_N;
    assign rd_rise  = !re_q && iRE_N && !iCE_N;

    // Busy request raised by the command decoder, applied after the decode.
    logic             start_busy;
    logic [BusyW-1:0] start_len;
    state_e           start_next;

    always_comb begin
        state_d     = state_q;
        busy_next_d = busy_next_q;
        op_d        = op_q;
        addr_cnt_d  = addr_cnt_q;
        col_d       = col_q;
        row_d       = row_q;
        fail_d      = fail_q;
        busy_cnt_d  = busy_cnt_q;
        rb_n_d      = rb_n_q;
        id_idx_d    = id_idx_q;
        flash_q_d   = flash_q_q;
        q_oe_d      = q_oe_q;
        page_d      = page_q;
        array_d     = array_q;
        start_busy  = 1'b0;
        start_len   = '0;
        start_next  = StIdle;

        // Busy countdown runs regardless of state so a status read can
        // interrupt BUSY without stalling it.
        if (busy_cnt_q != '0) begin
            busy_cnt_d = busy_cnt_q - 1'b1;
            if (busy_cnt_q == BusyW'(1)) begin
                rb_n_d = 1'b1;
                if (state_q == StBusy) begin
                    state_d = busy_next_q;
                end
            end
        end

        // Read data path
        if (rd_fall) begin
            case (state_q)
                StOutPage: begin
                    flash_q_d = page_q[col_q];
                    q_oe_d    = 1'b1;
                end
                StOutStatus: begin
                    flash_q_d = {iWP_N, rb_n_q, 5'b0, fail_q};
                    q_oe_d    = 1'b1;
                end
                StOutId: begin
                    flash_q_d = (id_idx_q == 2'd0) ? ID_BYTE0 :
                                (id_idx_q == 2'd1) ? ID_BYTE1 : 8'h00;
                    q_oe_d    = 1'b1;
                end
                default: ;
            endcase
        end

        if (rd_rise) begin
            q_oe_d = 1'b0;
            if (state_q == StOutPage) begin
                col_d = col_q + 1'b1;
            end
            if (state_q == StOutId && id_idx_q != 2'd2) begin
                id_idx_d = id_idx_q + 2'd1;
            end
        end

        if (iCE_N) begin
            q_oe_d = 1'b0;
        end

        // Command decode
        if (cmd_stb) begin
            case (data_q)
                8'hFF: begin
                    fail_d     = 1'b0;
                    start_busy = 1'b1;
                    start_len  = BusyW'(RST_BUSY);
                    start_next = StIdle;
                end
                8'h70: begin
                    state_d = StOutStatus;
                end
                8'h00: begin
                    if (state_q != StBusy) begin
                        state_d    = StAddr;
                        op_d       = OpRead;
                        addr_cnt_d = 1'b0;
                    end
                end
                8'h80: begin
                    if (state_q != StBusy) begin
                        state_d    = StAddr;
                        op_d       = OpProg;
                        addr_cnt_d = 1'b0;
                        page_d     = '1;
                    end
                end
                8'h90: begin
                    if (state_q != StBusy) begin
                        state_d    = StAddr;
                        op_d       = OpId;
                        addr_cnt_d = 1'b0;
                    end
                end
                8'h30: begin
                    if (state_q == StRdConf) begin
                        page_d     = array_q[row_q];
                        start_busy = 1'b1;
                        start_len  = BusyW'(READ_BUSY);
                        start_next = StOutPage;
                    end
                end
                8'h10: begin
                    if (state_q == StProgData) begin
                        if (iWP_N) begin
                            array_d[row_q] = page_q;
                            start_busy     = 1'b1;
                            start_len      = BusyW'(PROG_BUSY);
                            start_next     = StIdle;
                        end else begin
                            fail_d  = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
                default: ;
            endcase
        end

        // Address cycles: column then row; Read-ID takes a single byte.
        if (addr_stb && state_q == StAddr) begin
            if (op_q == OpId) begin
                state_d  = StOutId;
                id_idx_d = 2'd0;
            end else if (!addr_cnt_q) begin
                col_d      = data_q[ColW-1:0];
                addr_cnt_d = 1'b1;
            end else begin
                row_d   = data_q[RowW-1:0];
                state_d = (op_q == OpProg) ? StProgData : StRdConf;
            end
        end

        if (data_stb && state_q == StProgData) begin
            page_d[col_q] = data_q;
            col_d         = col_q + 1'b1;
        end

        // A zero-length busy skips straight to the follow-on state.
        if (start_busy) begin
            busy_next_d = start_next;
            if (start_len == '0) begin
                state_d    = start_next;
                busy_cnt_d = '0;
                rb_n_d     = 1'b1;
            end else begin
                state_d    = StBusy;
                busy_cnt_d = start_len;
                rb_n_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            we_q        <= 1'b1;
            re_q        <= 1'b1;
            cle_q       <= 1'b0;
            ale_q       <= 1'b0;
            data_q      <= 8'h00;
            state_q     <= StIdle;
            busy_next_q <= StIdle;
            op_q        <= OpRead;
            addr_cnt_q  <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            fail_q      <= 1'b0;
            busy_cnt_q  <= '0;
            rb_n_q      <= 1'b1;
            id_idx_q    <= 2'd0;
            flash_q_q   <= 8'h00;
            q_oe_q      <= 1'b0;
            page_q      <= '1;
            array_q     <= '1;
        end else begin
            we_q        <= iWE_N;
            re_q        <= iRE_N;
            cle_q       <= iCLE;
            ale_q       <= iALE;
            data_q      <= flash_data;
            state_q     <= state_d;
            busy_next_q <= busy_next_d;
            op_q        <= op_d;
            addr_cnt_q  <= addr_cnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            fail_q      <= fail_d;
            busy_cnt_q  <= busy_cnt_d;
            rb_n_q      <= rb_n_d;
            id_idx_q    <= id_idx_d;
            flash_q_q   <= flash_q_d;
            q_oe_q      <= q_oe_d;
            page_q      <= page_d;
            array_q     <= array_d;
        end
    end

    assign oRB_N   = rb_n_q;
    assign flash_q = flash_q_q;
    // Release the bus as soon as the chip is deselected.
    assign q_oe    = q_oe_q && !iCE_N;

endmodule

// File: tb/tb_nand_flash_target.sv
// -----------------------------------------------------------------------------
// tb_nand_flash_target
//
// Directed bench for nand_flash_target: drives pin-level command, address,
// data and read cycles and compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_nand_flash_target;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce_n, cle, ale, we_n, re_n, wp_n;
    logic [7:0] din;
    logic       rb_n;
    logic [7:0] q;
    logic       oe;

    int checks   = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    nand_flash_target dut (
        .clk        (clk),
        .rst        (rst),
        .iCE_N      (ce_n),
        .iCLE       (cle),
        .iALE       (ale),
        .iWE_N      (we_n),
        .iRE_N      (re_n),
        .iWP_N      (wp_n),
        .flash_data (din),
        .oRB_N      (rb_n),
        .flash_q    (q),
        .q_oe       (oe)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic write_cycle(input logic c, input logic a, input logic [7:0] d);
        @(negedge clk);
        cle  = c;
        ale  = a;
        din  = d;
        we_n = 1'b0;
        @(negedge clk);
        we_n = 1'b1;
        @(negedge clk);
        cle = 1'b0;
        ale = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] d);
        write_cycle(1'b1, 1'b0, d);
    endtask

    task automatic addr(input logic [7:0] d);
        write_cycle(1'b0, 1'b1, d);
    endtask

    task automatic wdata(input logic [7:0] d);
        write_cycle(1'b0, 1'b0, d);
    endtask

    // Counts low oRB_N samples, one per cycle, bounded.
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (rb_n === 1'b0 && cnt < 500) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic read_check(input string tag, input logic [7:0] exp);
        @(negedge clk);
        re_n = 1'b0;
        @(negedge clk);
        check_eq(tag, {23'd0, oe, q}, {23'd0, 1'b1, exp});
        re_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic page_read(input logic [7:0] col, input logic [7:0] row);
        cmd(8'h00);
        addr(col);
        addr(row);
        cmd(8'h30);
        wait_ready(n);
        check_eq("read_busy_len", n, 8);
    endtask

    initial begin
        rst  = 1'b0;
        ce_n = 1'b0;
        cle  = 1'b0;
        ale  = 1'b0;
        we_n = 1'b1;
        re_n = 1'b1;
        wp_n = 1'b1;
        din  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset state
        check_eq("reset_rb_n", rb_n, 1);
        check_eq("reset_q_oe", oe, 0);
        check_eq("reset_flash_q", q, 8'h00);

        // Status after reset
        cmd(8'h70);
        read_check("status_idle", 8'hC0);
        check_eq("oe_after_rise", oe, 0);

        // Read ID
        cmd(8'h90);
        addr(8'h00);
        read_check("id0", 8'hEC);
        read_check("id1", 8'hD3);
        read_check("id2", 8'h00);

        // Program row 1 starting at column 14 (wraps into column 0)
        cmd(8'h80);
        addr(8'h0E);
        addr(8'h01);
        wdata(8'h11);
        wdata(8'h22);
        wdata(8'h33);
        cmd(8'h10);
        wait_ready(n);
        check_eq("prog_busy_len", n, 20);

        page_read(8'h0E, 8'h01);
        read_check("rd_col14", 8'h11);
        read_check("rd_col15", 8'h22);
        read_check("rd_col0_wrap", 8'h33);
        read_check("rd_col1", 8'hFF);

        // Write-protected program: no busy, fail flag set
        wp_n = 1'b0;
        cmd(8'h80);
        addr(8'h00);
        addr(8'h02);
        wdata(8'hAA);
        cmd(8'h10);
        check_eq("wp_no_busy", rb_n, 1);
        @(negedge clk);
        check_eq("wp_no_busy_later", rb_n, 1);
        cmd(8'h70);
        read_check("status_wp_fail", 8'h41);
        wp_n = 1'b1;
        page_read(8'h00, 8'h02);
        read_check("wp_row2_col0", 8'hFF);
        read_check("wp_row2_col1", 8'hFF);

        // Reset command clears fail
        cmd(8'hFF);
        wait_ready(n);
        check_eq("rst_busy_len", n, 4);

        // Status during program busy
        cmd(8'h80);
        addr(8'h00);
        addr(8'h03);
        wdata(8'h5A);
        cmd(8'h10);
        cmd(8'h70);
        read_check("status_busy", 8'h80);
        wait_ready(n);
        check_eq("busy_ends", rb_n, 1);
        read_check("status_ready", 8'hC0);

        // Reset command aborts PROG_DATA; array untouched
        cmd(8'h80);
        addr(8'h00);
        addr(8'h01);
        wdata(8'h99);
        cmd(8'hFF);
        wait_ready(n);
        check_eq("abort_busy_len", n, 4);
        cmd(8'h70);
        read_check("status_after_abort", 8'hC0);
        page_read(8'h00, 8'h01);
        read_check("abort_row1_col0", 8'h33);

        // Pin reset during program busy clears busy and array
        cmd(8'h80);
        addr(8'h00);
        addr(8'h00);
        cmd(8'h10);
        check_eq("busy_before_rst", rb_n, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_clears_busy", rb_n, 1);
        rst = 1'b1;
        @(negedge clk);
        page_read(8'h00, 8'h01);
        read_check("rst_clears_array", 8'hFF);

        // Chip deselect drops q_oe at once
        cmd(8'h70);
        @(negedge clk);
        re_n = 1'b0;
        @(negedge clk);
        check_eq("ce_oe_on", oe, 1);
        ce_n = 1'b1;
        #1;
        check_eq("ce_oe_drop", oe, 0);
        @(negedge clk);
        re_n = 1'b1;
        @(negedge clk);
        ce_n = 1'b0;
        @(negedge clk);
        check_eq("ce_oe_stays_low", oe, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
